// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//
// Pipeline-control master for the 5-stage core (IF, ID, EX, MEM, WB).
// It decodes the instruction sitting in ID and keeps shadow copies of the
// register-usage fields of the instructions in EX, MEM and WB. From these it
// derives:
//   * the load-use stall (hold PC and IF/ID, insert a bubble into EX),
//   * the redirect flush when EX resolves a taken branch or jump,
//   * the EX operand forwarding selects,
//   * saturating performance counters for stalls and redirects.
//
// Parameters
//   CNT_W     width of the stall / flush performance counters
//   X0_GUARD  1: a destination of x0 never matches for stall or forwarding
//             0: x0 is compared like any other register
//
// Ports
//   clock        in   core clock, all state updates on the rising edge
//   resetn       in   synchronous reset, active HIGH (legacy port name)
//   instruction  in   instruction currently in ID (IF/ID register output)
//   PCSelR       in   EX-stage redirect (taken branch / JAL / JALR)
//   PCEn         out  1 = PC register loads the next PC
//   IFIDEn       out  1 = IF/ID register loads
//   IFIDFlush    out  1 = IF/ID register loads a NOP on the next edge
//   En1..En3     out  load enables of the ID/EX, EX/MEM, MEM/WB registers
//   reset1..3    out  bubble (clear) of the ID/EX, EX/MEM, MEM/WB controls
//   ForwardA/B   out  EX operand source: 00 regfile, 01 MEM ALU, 10 WB data
//   StallCount   out  cycles spent in a load-use stall, saturating
//   FlushCount   out  redirect events, saturating
// -----------------------------------------------------------------------------
module hazard_control_unit #(
  parameter int CNT_W    = 32,
  parameter bit X0_GUARD = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [31:0]      instruction,
  input  logic             PCSelR,
  output logic             PCEn,
  output logic             IFIDEn,
  output logic             IFIDFlush,
  output logic             En1,
  output logic             En2,
  output logic             En3,
  output logic             reset1,
  output logic             reset2,
  output logic             reset3,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  // ---------------------------------------------------------------------------
  // Opcodes that matter for hazard detection
  // ---------------------------------------------------------------------------
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Register-usage summary of one instruction, carried down the pipe.
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       reg_wen;
    logic       is_load;
  } shadow_t;

  // What the control unit asks of the pipeline this cycle.
  typedef enum logic [1:0] {
    MODE_NORMAL,
    MODE_STALL,
    MODE_REDIRECT,
    MODE_RESET
  } mode_e;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Unknown opcodes decode to an all-zero usage summary, i.e. a bubble.
  function automatic shadow_t decode(input logic [31:0] instr);
    shadow_t d;
    d          = '0;
    d.rd       = instr[11:7];
    d.rs1      = instr[19:15];
    d.rs2      = instr[24:20];
    case (instr[6:0])
      OP_REG: begin
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b1;
        d.reg_wen  = 1'b1;
      end
      OP_IMM: begin
        d.uses_rs1 = 1'b1;
        d.reg_wen  = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b1;
      end
      OP_LOAD: begin
        d.uses_rs1 = 1'b1;
        d.reg_wen  = 1'b1;
        d.is_load  = 1'b1;
      end
      OP_JALR: begin
        d.uses_rs1 = 1'b1;
        d.reg_wen  = 1'b1;
      end
      OP_JAL: begin
        d.reg_wen  = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

  // A producer's rd matches a consumer's rs; with the guard on, writes to
  // x0 are discarded by the register file and therefore never match.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd == rs) && !(X0_GUARD && (rd == 5'd0));
  endfunction

  // MEM wins over WB because it holds the younger value. A load in MEM has
  // no data yet, so it cannot forward; that case is covered by the stall.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic      uses,
                                         input shadow_t   mem,
                                         input shadow_t   wb);
    if (uses && mem.reg_wen && !mem.is_load && reg_match(mem.rd, rs)) begin
      return FWD_MEM;
    end else if (uses && wb.reg_wen && reg_match(wb.rd, rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  shadow_t             ex_q, ex_d;
  shadow_t             mem_q, mem_d;
  shadow_t             wb_q, wb_d;
  logic    [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic    [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  shadow_t             id_dec;
  logic                load_use;
  mode_e               mode;

  assign id_dec = decode(instruction);

  // The consumer in ID needs a value that the load in EX produces only at
  // the end of MEM, so one bubble is unavoidable.
  assign load_use = ex_q.is_load && ex_q.reg_wen &&
                    ((id_dec.uses_rs1 && reg_match(ex_q.rd, id_dec.rs1)) ||
                     (id_dec.uses_rs2 && reg_match(ex_q.rd, id_dec.rs2)));

  // Redirect beats stall: the stalled consumer is on the wrong path and
  // is being killed anyway.
  always_comb begin
    if (resetn) begin
      mode = MODE_RESET;
    end else if (PCSelR) begin
      mode = MODE_REDIRECT;
    end else if (load_use) begin
      mode = MODE_STALL;
    end else begin
      mode = MODE_NORMAL;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    PCEn      = 1'b1;
    IFIDEn    = 1'b1;
    IFIDFlush = 1'b0;
    En1       = 1'b1;
    En2       = 1'b1;
    En3       = 1'b1;
    reset1    = 1'b0;
    reset2    = 1'b0;
    reset3    = 1'b0;
    ForwardA  = fwd_sel(ex_q.rs1, ex_q.uses_rs1, mem_q, wb_q);
    ForwardB  = fwd_sel(ex_q.rs2, ex_q.uses_rs2, mem_q, wb_q);

    case (mode)
      MODE_RESET: begin
        PCEn      = 1'b0;
        IFIDEn    = 1'b0;
        IFIDFlush = 1'b1;
        reset1    = 1'b1;
        reset2    = 1'b1;
        reset3    = 1'b1;
        ForwardA  = FWD_RF;
        ForwardB  = FWD_RF;
      end
      MODE_REDIRECT: begin
        // PC loads the target; the wrong-path instructions in IF and ID die.
        IFIDFlush = 1'b1;
        reset1    = 1'b1;
      end
      MODE_STALL: begin
        // Hold IF and ID, let EX/MEM/WB drain, feed a bubble into EX.
        PCEn      = 1'b0;
        IFIDEn    = 1'b0;
        reset1    = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shadow pipeline and counters, next state
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;

    if (reset1) begin
      ex_d = '0;
    end else if (En1) begin
      ex_d = id_dec;
    end

    if (reset2) begin
      mem_d = '0;
    end else if (En2) begin
      mem_d = ex_q;
    end

    if (reset3) begin
      wb_d = '0;
    end else if (En3) begin
      wb_d = mem_q;
    end
  end

  // Counters stop at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((mode == MODE_STALL) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((mode == MODE_REDIRECT) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (resetn) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

  // Fields carried for completeness of the WB shadow (and instruction bits
  // that do not affect hazards) have no consumer here.
  logic unused_bits;
  assign unused_bits = ^{instruction[31:25], instruction[14:12],
                         wb_q.rs1, wb_q.rs2, wb_q.uses_rs1, wb_q.uses_rs2,
                         wb_q.is_load};

endmodule
